// File: rtl/spi_regbank_burst.sv
// SPI slave config/status register bank; all four SPI modes, mode latched per transaction.
// Define SPI_REGBANK_BURST_EN for multi-word bursts with address auto-increment.
module spi_regbank_burst #(
   parameter int unsigned          NUM_CFG       = 8,
   parameter int unsigned          NUM_STATUS    = 8,
   parameter int unsigned          REG_WIDTH     = 8,
   parameter int unsigned          ADDR_WIDTH    = 7,
   parameter int unsigned          SYNC_STAGES   = 2,
   parameter logic [REG_WIDTH-1:0] CFG_RESET_VAL = '0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cpol,
   input  logic                            cpha,
   input  logic                            spi_cs_n,
   input  logic                            spi_clk,
   input  logic                            spi_mosi,
   output logic                            spi_miso,
   output logic                            spi_miso_oe,
   input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
   output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
   output logic [NUM_CFG-1:0]              cfg_wr_pulse
);

   localparam int unsigned NUM_REGS = NUM_CFG + NUM_STATUS;
   localparam int unsigned SR_W     = (REG_WIDTH > ADDR_WIDTH + 1) ? REG_WIDTH : ADDR_WIDTH + 1;
   localparam int unsigned CNT_W    = $clog2(SR_W) + 1;

   typedef enum logic [2:0] {StIdle, StCmd, StRdata, StWdata, StDone} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync, cpol_sync, cpha_sync;
   logic                   cs_s, sclk_s, mosi_s;
   logic                   cs_prev_q, sclk_prev_q;
   logic                   cpol_q, cpol_d, cpha_q, cpha_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d, addr_inc, cmd_addr, rd_addr;
   logic [SR_W-2:0]        rx_q, rx_d;
   logic [REG_WIDTH-1:0]   tx_q, tx_d, rd_data, wdata;
   logic                   skip_q, skip_d;
   logic [REG_WIDTH-1:0]   cfg_q [NUM_CFG];
   logic [REG_WIDTH-1:0]   cfg_d [NUM_CFG];
   logic [NUM_CFG-1:0]     pulse_q, pulse_d;
   logic                   cs_fall, cs_rise, sclk_rise, sclk_fall, lead, trail, sample, shift;
   logic                   cmd_rw;

   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   assign cs_fall   = cs_prev_q & ~cs_s;
   assign cs_rise   = ~cs_prev_q & cs_s;
   assign sclk_rise = ~sclk_prev_q & sclk_s;
   assign sclk_fall = sclk_prev_q & ~sclk_s;
   assign lead      = cpol_q ? sclk_fall : sclk_rise;
   assign trail     = cpol_q ? sclk_rise : sclk_fall;
   assign sample    = cpha_q ? trail : lead;
   assign shift     = cpha_q ? lead : trail;

   assign cmd_rw   = rx_q[ADDR_WIDTH-1];
   assign cmd_addr = {rx_q[ADDR_WIDTH-2:0], mosi_s};
   assign wdata    = {rx_q[REG_WIDTH-2:0], mosi_s};
   assign addr_inc = (addr_q == ADDR_WIDTH'(NUM_REGS - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
   assign rd_addr  = (state_q == StCmd) ? cmd_addr : addr_inc;

   always_comb begin
      rd_data = '0;
      for (int unsigned k = 0; k < NUM_CFG; k++) begin
         if (rd_addr == ADDR_WIDTH'(k)) rd_data = cfg_q[k];
      end
      for (int unsigned k = 0; k < NUM_STATUS; k++) begin
         if (rd_addr == ADDR_WIDTH'(NUM_CFG + k)) rd_data = status_regs[k*REG_WIDTH +: REG_WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      skip_d  = skip_q;
      cfg_d   = cfg_q;
      pulse_d = '0;
      if (cs_rise && state_q != StIdle) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cs_fall) begin
                  state_d = StCmd;
                  cnt_d   = '0;
                  cpol_d  = cpol_sync[SYNC_STAGES-1];
                  cpha_d  = cpha_sync[SYNC_STAGES-1];
               end
            end
            StCmd: begin
               if (sample) begin
                  rx_d = {rx_q[SR_W-3:0], mosi_s};
                  if (cnt_q == CNT_W'(ADDR_WIDTH)) begin
                     cnt_d  = '0;
                     addr_d = cmd_addr;
                     if (cmd_rw) begin
                        state_d = StWdata;
                     end else begin
                        state_d = StRdata;
                        tx_d    = rd_data;
                        skip_d  = 1'b1;
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            StRdata: begin
               // The first shift edge after a load must leave the MSB on the line.
               if (shift) begin
                  if (skip_q) skip_d = 1'b0;
                  else        tx_d   = {tx_q[REG_WIDTH-2:0], 1'b0};
               end
               if (sample) begin
                  if (cnt_q == CNT_W'(REG_WIDTH - 1)) begin
                     cnt_d = '0;
`ifdef SPI_REGBANK_BURST_EN
                     addr_d = addr_inc;
                     tx_d   = rd_data;
                     skip_d = 1'b1;
`else
                     state_d = StDone;
`endif
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            StWdata: begin
               if (sample) begin
                  rx_d = {rx_q[SR_W-3:0], mosi_s};
                  if (cnt_q == CNT_W'(REG_WIDTH - 1)) begin
                     cnt_d = '0;
                     for (int unsigned k = 0; k < NUM_CFG; k++) begin
                        if (addr_q == ADDR_WIDTH'(k)) begin
                           cfg_d[k]   = wdata;
                           pulse_d[k] = 1'b1;
                        end
                     end
`ifdef SPI_REGBANK_BURST_EN
                     addr_d = addr_inc;
`else
                     state_d = StDone;
`endif
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            StDone: ;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // cs sync resets low so a select held across reset never looks like a new falling edge.
         cs_sync     <= '0;
         sclk_sync   <= '0;
         mosi_sync   <= '0;
         cpol_sync   <= '0;
         cpha_sync   <= '0;
         cs_prev_q   <= 1'b0;
         sclk_prev_q <= 1'b0;
         state_q     <= StIdle;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         cnt_q       <= '0;
         addr_q      <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         skip_q      <= 1'b0;
         pulse_q     <= '0;
         for (int unsigned k = 0; k < NUM_CFG; k++) cfg_q[k] <= CFG_RESET_VAL;
      end else begin
         cs_sync     <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
         mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         cpol_sync   <= {cpol_sync[SYNC_STAGES-2:0], cpol};
         cpha_sync   <= {cpha_sync[SYNC_STAGES-2:0], cpha};
         cs_prev_q   <= cs_s;
         sclk_prev_q <= sclk_s;
         state_q     <= state_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         skip_q      <= skip_d;
         pulse_q     <= pulse_d;
         cfg_q       <= cfg_d;
      end
   end

   for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg
      assign config_regs[k*REG_WIDTH +: REG_WIDTH] = cfg_q[k];
   end

   assign cfg_wr_pulse = pulse_q;
   assign spi_miso     = (state_q == StRdata) && !cs_s && tx_q[REG_WIDTH-1];
   assign spi_miso_oe  = !cs_s && (cs_fall || state_q != StIdle);

endmodule

// File: tb/tb_spi_regbank_burst.sv
// Self-checking bench for spi_regbank_burst: directed and random SPI transactions vs a register model.
module tb_spi_regbank_burst;

   localparam int NUM_CFG    = 8;
   localparam int NUM_STATUS = 8;
   localparam int NREGS      = NUM_CFG + NUM_STATUS;
   localparam int HALF       = 80;
`ifdef SPI_REGBANK_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic                         clk = 1'b0;
   logic                         rst, cpol, cpha, cs_n, sclk, mosi;
   logic                         spi_miso, spi_miso_oe;
   logic [NUM_STATUS*8-1:0]      status_regs;
   logic [NUM_CFG*8-1:0]         config_regs;
   logic [NUM_CFG-1:0]           cfg_wr_pulse;

   spi_regbank_burst #(
      .NUM_CFG      (NUM_CFG),
      .NUM_STATUS   (NUM_STATUS),
      .REG_WIDTH    (8),
      .ADDR_WIDTH   (7),
      .SYNC_STAGES  (2),
      .CFG_RESET_VAL(8'h00)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cpol        (cpol),
      .cpha        (cpha),
      .spi_cs_n    (cs_n),
      .spi_clk     (sclk),
      .spi_mosi    (mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .status_regs (status_regs),
      .config_regs (config_regs),
      .cfg_wr_pulse(cfg_wr_pulse)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int oe_drop = 0;
   int exp_pulses;
   logic [7:0] m_cfg [NUM_CFG];
   logic [7:0] m_stat [NUM_STATUS];
   logic [7:0] mosi_bytes [$];
   logic [7:0] miso_bytes [$];
   logic [7:0] exp_rd [$];

   int         pulse_total = 0;
   int         bad_pulse   = 0;
   logic [7:0] prev_pulse  = '0;
   logic [7:0] last_pulse  = '0;

   always @(negedge clk) begin
      pulse_total <= pulse_total + $countones(cfg_wr_pulse);
      if ($countones(cfg_wr_pulse) > 1 || (cfg_wr_pulse & prev_pulse) != '0)
         bad_pulse <= bad_pulse + 1;
      prev_pulse <= cfg_wr_pulse;
      if (cfg_wr_pulse != '0) last_pulse <= cfg_wr_pulse;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_cfg(input string tag);
      for (int k = 0; k < NUM_CFG; k++)
         check($sformatf("%s_cfg%0d", tag, k), 32'(config_regs[k*8 +: 8]), 32'(m_cfg[k]));
   endtask

   task automatic drive_status();
      for (int k = 0; k < NUM_STATUS; k++) status_regs[k*8 +: 8] = m_stat[k];
   endtask

   // Reference: walk the data words through the register map per the addressing rules.
   task automatic model_run(input int nwords);
      int a;
      bit rw;
      logic [7:0] cmd;
      cmd = mosi_bytes[0];
      rw  = cmd[7];
      a   = int'(cmd[6:0]);
      exp_rd.delete();
      exp_pulses = 0;
      for (int w = 0; w < nwords; w++) begin
         if (w > 0 && !BURST) begin
            exp_rd.push_back(8'h00);
         end else begin
            if (rw) begin
               if (a < NUM_CFG) begin
                  m_cfg[a] = mosi_bytes[w+1];
                  exp_pulses++;
               end
               exp_rd.push_back(8'h00);
            end else if (a < NUM_CFG) begin
               exp_rd.push_back(m_cfg[a]);
            end else if (a < NREGS) begin
               exp_rd.push_back(m_stat[a-NUM_CFG]);
            end else begin
               exp_rd.push_back(8'h00);
            end
            a = (a == NREGS - 1) ? 0 : (a + 1) % 128;
         end
      end
   endtask

   task automatic spi_xfer(input bit pol, input bit pha, input int nbits, input bit end_cs);
      logic [7:0] ob, ib;
      cpol = pol;
      cpha = pha;
      sclk = pol;
      #(HALF*2);
      cs_n = 1'b0;
      #HALF;
      ib = '0;
      for (int i = 0; i < nbits; i++) begin
         ob = mosi_bytes[i/8];
         if (!pha) begin
            mosi = ob[7 - i%8];
            #HALF;
            ib = {ib[6:0], spi_miso};
            if (spi_miso_oe !== 1'b1) oe_drop++;
            sclk = ~pol;
            #HALF;
            sclk = pol;
         end else begin
            sclk = ~pol;
            mosi = ob[7 - i%8];
            #HALF;
            ib = {ib[6:0], spi_miso};
            if (spi_miso_oe !== 1'b1) oe_drop++;
            sclk = pol;
            #HALF;
         end
         if (i % 8 == 7) miso_bytes.push_back(ib);
      end
      #HALF;
      if (end_cs) begin
         cs_n = 1'b1;
         #(HALF*2);
      end
   endtask

   task automatic run_txn(input string tag, input bit pol, input bit pha);
      int nw, p0, o0;
      nw = mosi_bytes.size() - 1;
      model_run(nw);
      miso_bytes.delete();
      p0 = pulse_total;
      o0 = oe_drop;
      spi_xfer(pol, pha, 8 * (nw + 1), 1'b1);
      check({tag, "_cmd_miso"}, 32'(miso_bytes[0]), 32'h0);
      for (int w = 0; w < nw; w++)
         check($sformatf("%s_rd%0d", tag, w), 32'(miso_bytes[w+1]), 32'(exp_rd[w]));
      check({tag, "_pulses"}, 32'(pulse_total - p0), 32'(exp_pulses));
      check({tag, "_oe_during"}, 32'(oe_drop - o0), 32'h0);
      check({tag, "_oe_after"}, 32'(spi_miso_oe), 32'h0);
      check_cfg(tag);
   endtask

   initial begin
      int p0;
      bit pol, pha, rw;
      int a, nw;
      rst  = 1'b1;
      cs_n = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      cpol = 1'b0;
      cpha = 1'b0;
      for (int k = 0; k < NUM_CFG; k++) m_cfg[k] = 8'h00;
      for (int k = 0; k < NUM_STATUS; k++) m_stat[k] = 8'(8'hA0 + k);
      m_stat[1] = 8'h10;
      drive_status();
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      check_cfg("reset");
      check("reset_pulse", 32'(cfg_wr_pulse), 32'h0);
      check("reset_miso", 32'(spi_miso), 32'h0);
      check("reset_oe", 32'(spi_miso_oe), 32'h0);

      mosi_bytes = '{8'h82, 8'h5A};
      run_txn("m0_wr", 1'b0, 1'b0);
      check("m0_wr_which", 32'(last_pulse), 32'h04);

      mosi_bytes = '{8'h09, 8'h00};
      run_txn("m0_rd9", 1'b0, 1'b0);
      mosi_bytes = '{8'h09, 8'h00};
      run_txn("m1_rd9", 1'b0, 1'b1);
      mosi_bytes = '{8'h09, 8'h00};
      run_txn("m2_rd9", 1'b1, 1'b0);
      mosi_bytes = '{8'h09, 8'h00};
      run_txn("m3_rd9", 1'b1, 1'b1);

      mosi_bytes = '{8'h86, 8'h11, 8'h22, 8'h33};
      run_txn("burst_wr6", 1'b0, 1'b0);
      mosi_bytes = '{8'h8E, 8'h44, 8'h55, 8'h66};
      run_txn("burst_wr14", 1'b1, 1'b1);
      mosi_bytes = '{8'h0E, 8'h00, 8'h00, 8'h00};
      run_txn("burst_rd14", 1'b0, 1'b1);
      mosi_bytes = '{8'h05, 8'h00, 8'h00, 8'h00};
      run_txn("burst_rd5", 1'b1, 1'b0);

      // Partial data word must be discarded.
      mosi_bytes = '{8'h81, 8'hFF};
      miso_bytes.delete();
      p0 = pulse_total;
      spi_xfer(1'b0, 1'b0, 13, 1'b1);
      check("abort_pulses", 32'(pulse_total - p0), 32'h0);
      check("abort_oe", 32'(spi_miso_oe), 32'h0);
      check_cfg("abort");
      mosi_bytes = '{8'h81, 8'h3C};
      run_txn("after_abort", 1'b1, 1'b1);

      mosi_bytes = '{8'h7F, 8'h00};
      run_txn("rd_oor", 1'b0, 1'b0);
      mosi_bytes = '{8'h8A, 8'hC3};
      run_txn("wr_status", 1'b0, 1'b1);

      for (int t = 0; t < 16; t++) begin
         pol = 1'($urandom_range(0, 1));
         pha = 1'($urandom_range(0, 1));
         rw  = 1'($urandom_range(0, 1));
         a   = ($urandom_range(0, 7) == 0) ? 127 : int'($urandom_range(0, 19));
         nw  = int'($urandom_range(1, 3));
         for (int k = 0; k < NUM_STATUS; k++) m_stat[k] = 8'($urandom);
         drive_status();
         mosi_bytes.delete();
         mosi_bytes.push_back({rw, 7'(a)});
         for (int w = 0; w < nw; w++) mosi_bytes.push_back(8'($urandom));
         run_txn($sformatf("rnd%0d", t), pol, pha);
      end

      // Reset in the middle of a burst write, with cs_n held low throughout.
      mosi_bytes = '{8'h80, 8'h12, 8'h34};
      miso_bytes.delete();
      spi_xfer(1'b0, 1'b0, 20, 1'b0);
      check("pre_rst_cfg0", 32'(config_regs[7:0]), 32'h12);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < NUM_CFG; k++) m_cfg[k] = 8'h00;
      repeat (3) @(negedge clk);
      check_cfg("rst_mid");
      check("rst_mid_oe", 32'(spi_miso_oe), 32'h0);
      check("rst_mid_miso", 32'(spi_miso), 32'h0);
      p0 = pulse_total;
      mosi = 1'b1;
      for (int i = 0; i < 24; i++) begin
         sclk = ~sclk;
         #HALF;
      end
      check("rst_abandon_pulses", 32'(pulse_total - p0), 32'h0);
      check("rst_abandon_oe", 32'(spi_miso_oe), 32'h0);
      check_cfg("rst_abandon");
      cs_n = 1'b1;
      #(HALF*2);
      mosi_bytes = '{8'h83, 8'h99};
      run_txn("after_rst", 1'b0, 1'b0);

      check("pulse_shape", 32'(bad_pulse), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
